// File: rtl/ysyx_lsu.sv
// rtl/ysyx_lsu.sv - load/store unit between execute stage and a req/gnt/rvalid data-memory port
//
// Purpose: executes one data-memory access per accepted request (lb/lbu/lh/lhu/lw,
// sb/sh/sw). It aligns store lanes and builds write strobes, extracts and extends
// load data, and reports misaligned or illegal encodings and timeouts as errors.
// Every accepted request gets exactly one response.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid / req_ready           core request handshake (ready only in IDLE)
//   dm_rd_sel, dm_wr_sel            decoded load/store selector
//   addr, wdata                     byte address and store data
//   resp_valid/resp_rdata/resp_err  registered one-cycle completion pulse
//   mem_req/we/addr/wdata/wstrb     memory request, held until mem_gnt
//   mem_gnt, mem_rvalid, mem_rdata  memory grant and response

module ysyx_lsu #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  dm_rd_sel,
  input  logic [1:0]  dm_wr_sel,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW:0] TMO_LIM = (CW + 1)'(TIMEOUT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [2:0] RD_NONE = 3'd0;
  localparam logic [2:0] RD_LB   = 3'd1;
  localparam logic [2:0] RD_LBU  = 3'd2;
  localparam logic [2:0] RD_LH   = 3'd3;
  localparam logic [2:0] RD_LHU  = 3'd4;
  localparam logic [2:0] RD_LW   = 3'd5;

  localparam logic [1:0] WR_NONE = 2'd0;
  localparam logic [1:0] WR_SB   = 2'd1;
  localparam logic [1:0] WR_SH   = 2'd2;
  localparam logic [1:0] WR_SW   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    rd_sel_q, rd_sel_d;
  logic [1:0]    addr_lo_q, addr_lo_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [3:0]    mem_wstrb_q, mem_wstrb_d;
  logic          resp_valid_q, resp_valid_d;
  logic          resp_err_q, resp_err_d;
  logic [31:0]   resp_rdata_q, resp_rdata_d;

  // Request classification on the incoming (not yet latched) fields.
  logic rd_act, wr_act, rd_bad, is_half, is_word, req_err;

  always_comb begin
    rd_act  = (dm_rd_sel != RD_NONE);
    wr_act  = (dm_wr_sel != WR_NONE);
    rd_bad  = (dm_rd_sel > RD_LW);
    is_half = (dm_rd_sel == RD_LH) || (dm_rd_sel == RD_LHU) || (dm_wr_sel == WR_SH);
    is_word = (dm_rd_sel == RD_LW) || (dm_wr_sel == WR_SW);
    // rd_act == wr_act catches both "neither" and "both" selectors.
    req_err = (rd_act == wr_act) || rd_bad
            || (is_half && addr[0])
            || (is_word && (addr[1:0] != 2'b00));
  end

  // Store lane replication and byte enables; loads leave both at zero.
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;

  always_comb begin
    st_wdata = 32'h0;
    st_wstrb = 4'b0000;
    case (dm_wr_sel)
      WR_SB: begin
        st_wdata = {4{wdata[7:0]}};
        st_wstrb = 4'b0001 << addr[1:0];
      end
      WR_SH: begin
        st_wdata = {2{wdata[15:0]}};
        st_wstrb = addr[1] ? 4'b1100 : 4'b0011;
      end
      WR_SW: begin
        st_wdata = wdata;
        st_wstrb = 4'b1111;
      end
      default: begin
        st_wdata = 32'h0;
        st_wstrb = 4'b0000;
      end
    endcase
  end

  // Load extraction uses the latched offset; stores fall to the default (0).
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  always_comb begin
    ld_byte = mem_rdata[{addr_lo_q, 3'b000} +: 8];
    ld_half = mem_rdata[{addr_lo_q[1], 4'b0000} +: 16];
    case (rd_sel_q)
      RD_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      RD_LBU:  ld_data = {24'h0, ld_byte};
      RD_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      RD_LHU:  ld_data = {16'h0, ld_half};
      RD_LW:   ld_data = mem_rdata;
      default: ld_data = 32'h0;
    endcase
  end

  // Counter is one bit wider in the compare so a grant on the last allowed
  // cycle still gets one WAIT cycle without wrapping.
  logic [CW:0] cnt_inc;
  logic        tmo_hit;

  always_comb begin
    cnt_inc = {1'b0, cnt_q} + 1'b1;
    tmo_hit = (cnt_inc >= TMO_LIM);
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rd_sel_d     = rd_sel_q;
    addr_lo_d    = addr_lo_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'h0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          rd_sel_d  = dm_rd_sel;
          addr_lo_d = addr[1:0];
          if (req_err) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d     = S_REQ;
            cnt_d       = '0;
            mem_we_d    = wr_act;
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_wdata_d = st_wdata;
            mem_wstrb_d = st_wstrb;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_inc[CW-1:0];
        if (mem_gnt) begin
          state_d = S_WAIT;
        end else if (tmo_hit) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_inc[CW-1:0];
        if (mem_rvalid) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = ld_data;
        end else if (tmo_hit) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      rd_sel_q     <= RD_NONE;
      addr_lo_q    <= 2'b00;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      mem_wstrb_q  <= 4'b0000;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_sel_q     <= rd_sel_d;
      addr_lo_q    <= addr_lo_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // mem_req decodes straight from state so reset drops it without a clock.
  assign req_ready  = (state_q == S_IDLE);
  assign mem_req    = (state_q == S_REQ);
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_ysyx_lsu.sv
// tb/tb_ysyx_lsu.sv - self-checking bench for ysyx_lsu with a behavioural reference model

module tb_ysyx_lsu;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  dm_rd_sel;
  logic [1:0]  dm_wr_sel;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  ysyx_lsu #(.TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .dm_rd_sel(dm_rd_sel), .dm_wr_sel(dm_wr_sel),
    .addr(addr), .wdata(wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: rules of the access written as plain arithmetic.
  function automatic bit model_err(input int rd, input int wr, input logic [31:0] a);
    int lo;
    lo = int'(a[1:0]);
    if (rd > 5) return 1;
    if ((rd == 0) == (wr == 0)) return 1;
    if ((rd == 3 || rd == 4 || wr == 2) && (lo % 2 != 0)) return 1;
    if ((rd == 5 || wr == 3) && lo != 0) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] model_load(input int rd, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (int'(a[1:0]) * 8)) & 32'hFF;
    h = (w >> (int'(a[1]) * 16)) & 32'hFFFF;
    case (rd)
      1: return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      2: return b;
      3: return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      4: return h;
      5: return w;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_wstrb(input int wr, input logic [31:0] a);
    case (wr)
      1: return 32'd1 << int'(a[1:0]);
      2: return (a[1]) ? 32'hC : 32'h3;
      3: return 32'hF;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input int wr, input logic [31:0] d);
    case (wr)
      1: return (d & 32'hFF) * 32'h0101_0101;
      2: return (d & 32'hFFFF) * 32'h0001_0001;
      3: return d;
      default: return 32'h0;
    endcase
  endfunction

  // One access from acceptance (cycle 0) to the cycle after its response.
  // gd = cycles mem_gnt is withheld; rdv = extra cycles before mem_rvalid.
  task automatic run_access(input string tag, input int rd, input int wr,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rdat, input int gd, input int rdv,
                            input bit rv_never);
    bit e, fail;
    int g, kt, w_end, exp_c, req_hi, resp_n, resp_c;
    logic [31:0] exp_rd, resp_d;
    logic resp_e;
    e = model_err(rd, wr, a);
    g = gd + 1;
    resp_n = 0; resp_c = -1; resp_d = 32'h0; resp_e = 1'b0;
    if (e) begin
      exp_c = 1; fail = 1; req_hi = 0;
    end else begin
      req_hi = (g < T) ? g : T;
      if (g > T) begin
        exp_c = T + 1; fail = 1;
      end else begin
        kt = (g + 1 > T) ? g + 1 : T;
        w_end = g + 1 + rdv;
        if (!rv_never && w_end <= kt) begin
          exp_c = w_end + 1; fail = 0;
        end else begin
          exp_c = kt + 1; fail = 1;
        end
      end
    end
    exp_rd = (fail || wr != 0) ? 32'h0 : model_load(rd, a, rdat);

    req_valid = 1'b1;
    dm_rd_sel = 3'(rd);
    dm_wr_sel = 2'(wr);
    addr      = a;
    wdata     = wd;
    @(negedge clk);
    check_eq({tag, ".ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    // Scramble inputs to prove the DUT works from latched values.
    req_valid = 1'b0;
    dm_rd_sel = 3'(~rd);
    dm_wr_sel = 2'(~wr);
    addr      = ~a;
    wdata     = ~wd;
    for (int c = 1; c <= exp_c + 1; c++) begin
      mem_gnt    = !e && (c == g);
      mem_rvalid = !e && !rv_never && (c == g + 1 + rdv);
      mem_rdata  = rdat;
      @(negedge clk);
      if (c == 1) check_eq({tag, ".busy"}, 32'(req_ready), 32'd0);
      check_eq({tag, ".mreq"}, 32'(mem_req), 32'(c <= req_hi));
      if (c <= req_hi) begin
        check_eq({tag, ".maddr"}, mem_addr, {a[31:2], 2'b00});
        check_eq({tag, ".mwe"}, 32'(mem_we), 32'(wr != 0));
        check_eq({tag, ".mwdata"}, mem_wdata, model_wdata(wr, wd));
        check_eq({tag, ".mwstrb"}, 32'(mem_wstrb), model_wstrb(wr, a));
      end
      if (resp_valid) begin
        resp_n++; resp_c = c; resp_d = resp_rdata; resp_e = resp_err;
      end
      @(posedge clk); #1;
    end
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    check_eq({tag, ".nresp"}, 32'(resp_n), 32'd1);
    check_eq({tag, ".lat"}, 32'(resp_c), 32'(exp_c));
    check_eq({tag, ".err"}, 32'(resp_e), 32'(fail));
    check_eq({tag, ".rdata"}, resp_d, exp_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int rd, wr, gd, rdv;
    logic [31:0] a;
    rst_n = 1'b0; req_valid = 1'b0; dm_rd_sel = 3'd0; dm_wr_sel = 2'd0;
    addr = 32'h0; wdata = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    #2;
    check_eq("rst.ready", 32'(req_ready), 32'd1);
    check_eq("rst.rvalid", 32'(resp_valid), 32'd0);
    check_eq("rst.rerr", 32'(resp_err), 32'd0);
    check_eq("rst.rdata", resp_rdata, 32'd0);
    check_eq("rst.mreq", 32'(mem_req), 32'd0);
    check_eq("rst.mwe", 32'(mem_we), 32'd0);
    check_eq("rst.maddr", mem_addr, 32'd0);
    check_eq("rst.mwdata", mem_wdata, 32'd0);
    check_eq("rst.mwstrb", 32'(mem_wstrb), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_access("lb",      1, 0, 32'h8000_0003, 32'h0,         32'h80FF_1234, 0, 0, 0);
    run_access("lbu",     2, 0, 32'h8000_0003, 32'h0,         32'h80FF_1234, 0, 0, 0);
    run_access("sh",      0, 2, 32'h8000_0002, 32'h0000_BEEF, 32'h1234_5678, 0, 0, 0);
    run_access("lw_mis",  5, 0, 32'h8000_0001, 32'h0,         32'h0,         0, 0, 0);
    run_access("both",    3, 1, 32'h8000_0000, 32'h0,         32'h0,         0, 0, 0);
    run_access("lh_gnt3", 3, 0, 32'h8000_0002, 32'h0,         32'h8001_7FFF, 3, 0, 0);
    run_access("tmo",     5, 0, 32'h8000_0000, 32'h0,         32'hDEAD_BEEF, 0, 0, 1);
    run_access("lw_ok",   5, 0, 32'h8000_0004, 32'h0,         32'hCAFE_F00D, 0, 1, 0);
    run_access("rd_ill",  6, 0, 32'h8000_0000, 32'h0,         32'h0,         0, 0, 0);
    run_access("none",    0, 0, 32'h8000_0000, 32'h0,         32'h0,         0, 0, 0);
    run_access("sb1",     0, 1, 32'h8000_0001, 32'h1234_56A5, 32'h0,         1, 2, 0);
    run_access("lhu_odd", 4, 0, 32'h8000_0003, 32'h0,         32'h0,         0, 0, 0);

    // Reset while waiting for read data; a late rvalid must be ignored.
    req_valid = 1'b1; dm_rd_sel = 3'd5; dm_wr_sel = 2'd0; addr = 32'h8000_0010;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("arst.ready", 32'(req_ready), 32'd1);
    check_eq("arst.mreq", 32'(mem_req), 32'd0);
    check_eq("arst.maddr", mem_addr, 32'd0);
    check_eq("arst.mwe", 32'(mem_we), 32'd0);
    check_eq("arst.mwstrb", 32'(mem_wstrb), 32'd0);
    check_eq("arst.rvalid", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("late_rv.rvalid", 32'(resp_valid), 32'd0);
      check_eq("late_rv.ready", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
    end
    run_access("sw_post", 0, 3, 32'h8000_0020, 32'h0BAD_CAFE, 32'h0, 0, 0, 0);

    for (int n = 0; n < 60; n++) begin
      rd = $urandom_range(0, 7);
      wr = $urandom_range(0, 3);
      if ($urandom_range(0, 3) != 0) begin
        if ($urandom_range(0, 1) != 0) begin
          rd = $urandom_range(1, 5); wr = 0;
        end else begin
          rd = 0; wr = $urandom_range(1, 3);
        end
      end
      a = $urandom;
      if ($urandom_range(0, 1) != 0) a[1:0] = 2'b00;
      gd  = $urandom_range(0, 3);
      rdv = $urandom_range(0, 3);
      run_access("rnd", rd, wr, a, $urandom, $urandom, gd, rdv, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
